alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator side of the ALU datapath. Accepts queued host commands {op, src, operand}
//  and drives the ALU control/operand pins: on, rst, in_selector, out_selector, num1, num2.
//  Captures outputVal one cycle after issue and returns it to the host via valid/ready.
//  Keeps a shadow accumulator so the ALU operand DFFs stay stable between commands.
// PARAMETERS
//  W      8  data width (ALU is fixed at 8; other values unsupported)
//  DEPTH  4  command FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1    system clock
//  rst           in   1    reset: asynchronous, active-low
//  en            in   1    sequencer enable; drives alu_on
//  cmd_valid     in   1    host command valid
//  cmd_ready     out  1    FIFO not full
//  cmd_op        in   3    0 AND,1 OR,2 NOT,3 XOR,4 ADD,5 SUB,6 MULT; 7 reserved
//  cmd_src       in   2    0 A_IMM, 1 B_IMM, 2 CLR, 3 reserved
//  cmd_operand   in   W    immediate operand
//  res_valid     out  1    result beat valid
//  res_ready     in   1    host accepts result
//  res_data      out  W    captured outputVal
//  res_err       out  1    ALU reported S_run_error at capture
//  err_sticky    out  1    OR of all res_err since reset
//  alu_on        out  1    to ALU on
//  alu_rst       out  1    to ALU rst (active-high)
//  alu_in_sel    out  3    to in_selector: [2] persist, [1] load, [0] reset
//  alu_out_sel   out  7    to out_selector: [6] AND ... [0] MULT, one-hot
//  alu_num1      out  W    to num1 (accumulator load value)
//  alu_num2      out  W    to num2 (B operand)
//  alu_result    in   W    from outputVal
//  alu_state     in   2    from state: 00 off, 01 ready, 10 run, 11 run_error
// BEHAVIOUR
//  Reset (rst=0): FSM=IDLE; FIFO empty; acc_q=b_q=0; res_valid=0; res_data=0; res_err=0;
//   err_sticky=0; alu_on=0; alu_rst=1; alu_in_sel=001; alu_out_sel=1000000; num1=num2=0.
//   alu_rst deasserts on the first clk after rst release. alu_on = en registered (1 cycle).
//  FSM: IDLE -> ISSUE when FIFO non-empty AND en AND (!res_valid | res_ready).
//   ISSUE (1 cyc): pop FIFO; alu_out_sel=onehot(op); drive by src:
//     A_IMM: in_sel=010, num1=operand, num2=b_q
//     B_IMM: in_sel=010, num1=acc_q,   num2=operand; b_q<=operand
//     CLR:   in_sel=001 (ALU regs <= 0); b_q<=0
//   CAPT (1 cyc): in_sel=010, num1/num2 = values used in ISSUE; at clock edge
//     res_data<=alu_result, acc_q<=alu_result, res_valid<=1, res_err<=(alu_state==11);
//     err_sticky |= res_err. Next: ISSUE if eligible (back-to-back), else IDLE.
//  Latency: cmd accepted -> res_valid >= 3 cycles (enqueue, ISSUE, CAPT); 1 result/2 cycles.
//  Idle hold: outside ISSUE drive in_sel=010, num1=acc_q, num2=b_q, out_sel unchanged
//   (ALU DFFs reload identical values; outputVal stable). persist (100) is never driven.
//  Result handshake: beat held stable until res_valid&res_ready; ISSUE never starts while
//   an unconsumed beat would be overwritten. Accept and new capture in same cycle allowed.
//  FIFO: push on cmd_valid&cmd_ready; simultaneous push+pop when full permitted (ready=0
//   still; pop frees slot next cycle). Pointers wrap modulo DEPTH.
//  Arithmetic: ALU-defined, 8-bit wrap; sequencer never modifies result.
//  Reserved op/src: treated as AND / A_IMM; no error raised.
//  en falls mid-command: ISSUE/CAPT complete; no new ISSUE until en=1.
//  Reset mid-operation: all state to reset values immediately; in-flight cmds discarded.
// STRUCTURE
//  alu_pkg: op codes, onehot(op) table, src codes, in_selector codes (PERSIST/LOAD/RST),
//   ALU state codes (S_off..S_run_error), sequencer FSM state encoding.
//  Sub-module: alu_cmd_fifo (DEPTH x (3+2+W), valid/ready, async active-low reset).
// TESTING (bench = this block + ALU)
//  Reset: rst=0 mid-run -> all outputs at reset values; alu_rst=1 until 1st clk after release.
//  A_IMM 0x0F op ADD, then B_IMM 0x01 op ADD -> results 0x0F (A+b_q=0), then 0x10.
//  CLR, A_IMM 0xF0, B_IMM 0x3C op XOR -> 0x00, 0xF0, 0xCC; res_err=0.
//  A_IMM 0x20, B_IMM 0x10 op MULT (overflow) -> res_err=1 on that beat, err_sticky stays 1.
//  Hold res_ready=0, push 5 cmds (DEPTH=4) -> cmd_ready=0 after 4 queued; no beat lost.
//  Back-to-back 4 cmds, res_ready=1 -> res_valid every 2nd cycle, order preserved.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: shared codes for the ALU command sequencer.
package alu_cmd_sequencer_pkg;
    localparam int ALU_W = 8;
    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD, OP_SUB, OP_MULT, OP_RSVD
    } op_e;
    typedef enum logic [1:0] {SRC_A_IMM, SRC_B_IMM, SRC_CLR, SRC_RSVD} src_e;
    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RST     = 3'b001;
    typedef enum logic [1:0] {S_OFF, S_READY, S_RUN, S_RUN_ERROR} alu_state_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPT} seq_state_e;
    // out_selector is MSB-first: AND on bit 6 down to MULT on bit 0; reserved maps to AND.
    function automatic logic [6:0] onehot(input logic [2:0] op);
        return op == OP_RSVD ? 7'b1000000 : 7'b1000000 >> op;
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: host command and result channels of the ALU sequencer.
interface alu_cmd_sequencer_if #(parameter int W = 8);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [1:0]   cmd_src;
    logic [W-1:0] cmd_operand;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// alu_cmd_fifo: DEPTH-entry valid/ready command queue with wrapping pointers.
module alu_cmd_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [DW-1:0] push_data_i,
    output logic          pop_valid_o,
    input  logic          pop_ready_i,
    output logic [DW-1:0] pop_data_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;
    assign push_ready_o = cnt_q != (AW+1)'(DEPTH);
    assign pop_valid_o  = cnt_q != '0;
    assign pop_data_o   = mem_q[rd_q];
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_valid_o && pop_ready_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push ? wr_q + 1'b1 : wr_q;
            rd_q  <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= push && !pop ? cnt_q + 1'b1 : !push && pop ? cnt_q - 1'b1 : cnt_q;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data_i;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues queued host commands to the ALU pins and returns captured results.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    alu_cmd_sequencer_if.slave host,
    output logic               err_sticky_o,
    output logic               alu_on_o,
    output logic               alu_rst_o,
    output logic [2:0]         alu_in_sel_o,
    output logic [6:0]         alu_out_sel_o,
    output logic [W-1:0]       alu_num1_o,
    output logic [W-1:0]       alu_num2_o,
    input  logic [W-1:0]       alu_result_i,
    input  logic [1:0]         alu_state_i
);
    localparam int DW = 3 + 2 + W;
    seq_state_e    state_q, state_d;
    logic [W-1:0]  acc_q, b_q, n1_q, n2_q, res_data_q;
    logic [6:0]    out_sel_q;
    logic          res_valid_q, res_err_q, err_sticky_q, on_q, alu_rst_q;
    logic          fifo_valid, issue, capt, eligible, is_b, is_clr, cap_err;
    logic [DW-1:0] head;
    logic [2:0]    h_op;
    logic [1:0]    h_src;
    logic [W-1:0]  h_opnd, iss_num1, iss_num2;

    alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (host.cmd_valid),
        .push_ready_o (host.cmd_ready),
        .push_data_i  ({host.cmd_op, host.cmd_src, host.cmd_operand}),
        .pop_valid_o  (fifo_valid),
        .pop_ready_i  (issue),
        .pop_data_o   (head)
    );

    assign {h_op, h_src, h_opnd} = head;
    assign is_b     = h_src == SRC_B_IMM;
    assign is_clr   = h_src == SRC_CLR;
    assign iss_num1 = is_clr ? '0 : is_b ? acc_q : h_opnd;
    assign iss_num2 = is_clr ? '0 : is_b ? h_opnd : b_q;
    assign issue    = state_q == ST_ISSUE;
    // A fresh result waits in CAPT until the previous beat has been taken by the host.
    assign capt     = state_q == ST_CAPT && (!res_valid_q || host.res_ready);
    assign eligible = fifo_valid && en_i;
    assign cap_err  = alu_state_i == S_RUN_ERROR;

    always_comb begin
        state_d       = state_q;
        alu_in_sel_o  = IN_LOAD;
        alu_out_sel_o = out_sel_q;
        alu_num1_o    = acc_q;
        alu_num2_o    = b_q;
        case (state_q)
            ST_IDLE: state_d = eligible && (!res_valid_q || host.res_ready) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                state_d       = ST_CAPT;
                alu_in_sel_o  = is_clr ? IN_RST : IN_LOAD;
                alu_out_sel_o = onehot(h_op);
                alu_num1_o    = iss_num1;
                alu_num2_o    = iss_num2;
            end
            ST_CAPT: begin
                state_d    = !capt ? ST_CAPT : eligible ? ST_ISSUE : ST_IDLE;
                alu_num1_o = n1_q;
                alu_num2_o = n2_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (alu_rst_q) alu_in_sel_o = IN_RST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            b_q          <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
            out_sel_q    <= 7'b1000000;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            on_q         <= 1'b0;
            alu_rst_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            on_q      <= en_i;
            alu_rst_q <= 1'b0;
            if (issue) begin
                out_sel_q <= onehot(h_op);
                n1_q      <= iss_num1;
                n2_q      <= iss_num2;
                if (is_b || is_clr) b_q <= iss_num2;
            end
            if (capt) begin
                res_valid_q  <= 1'b1;
                res_data_q   <= alu_result_i;
                acc_q        <= alu_result_i;
                res_err_q    <= cap_err;
                err_sticky_q <= err_sticky_q | cap_err;
            end else if (host.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;
    assign host.res_err   = res_err_q;
    assign err_sticky_o   = err_sticky_q;
    assign alu_on_o       = on_q;
    assign alu_rst_o      = alu_rst_q;
endmodule
